// File: rtl/ghost_mover.sv
// Ghost position engine: holds the committed tile position, vets each controller
// proposal against bounds and the wall map, and slides pixel-by-pixel on legal moves.
module ghost_mover #(
    parameter int TILE     = 20,
    parameter int STEP     = 1,
    parameter int TICK_DIV = 500000,
    parameter int START_X  = 320,
    parameter int START_Y  = 240
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [9:0]   req_x,
    input  logic [8:0]   req_y,
    input  logic [767:0] tilemap_walls,
    output logic [9:0]   tile_x,
    output logic [8:0]   tile_y,
    output logic [9:0]   pos_x,
    output logic [8:0]   pos_y,
    output logic         ctrl_tick,
    output logic         moving,
    output logic         blocked
);
    localparam int               CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [9:0]       TILE_X   = 10'(TILE);
    localparam logic [8:0]       TILE_Y   = 9'(TILE);
    localparam logic [9:0]       STEP_X   = 10'(STEP);
    localparam logic [8:0]       STEP_Y   = 9'(STEP);
    localparam logic [9:0]       MAX_X    = 10'd620;
    localparam logic [8:0]       MAX_Y    = 9'd460;

    typedef enum logic [1:0] {S_ALIGNED, S_WAIT, S_CHECK, S_MOVE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       tile_x_q, tile_x_d, pos_x_q, pos_x_d, tgt_x_q, tgt_x_d;
    logic [8:0]       tile_y_q, tile_y_d, pos_y_q, pos_y_d, tgt_y_q, tgt_y_d;
    logic             ctrl_tick_q, ctrl_tick_d;
    logic             moving_q, moving_d;
    logic             blocked_q, blocked_d;

    logic             move_tick;
    logic             same_x, same_y, adj_x, adj_y, in_bounds, wall_hit;
    logic             is_stay, is_legal;
    logic [4:0]       col, row;
    logic [9:0]       step_x;
    logic [8:0]       step_y;

    assign move_tick = (cnt_q == CNT_LAST);

    // Adjacency is compared one bit wider so a wrapped "0 - TILE" never aliases.
    always_comb begin
        same_x    = (req_x == tile_x_q);
        same_y    = (req_y == tile_y_q);
        adj_x     = ({1'b0, req_x} == {1'b0, tile_x_q} + {1'b0, TILE_X}) ||
                    ({1'b0, tile_x_q} == {1'b0, req_x} + {1'b0, TILE_X});
        adj_y     = ({1'b0, req_y} == {1'b0, tile_y_q} + {1'b0, TILE_Y}) ||
                    ({1'b0, tile_y_q} == {1'b0, req_y} + {1'b0, TILE_Y});
        in_bounds = (req_x <= MAX_X) && (req_y <= MAX_Y);
        col       = 5'(req_x / TILE_X);
        row       = 5'(req_y / TILE_Y);
        wall_hit  = in_bounds ? tilemap_walls[{row, col}] : 1'b0;
        is_stay   = same_x && same_y;
        is_legal  = ((adj_x && same_y) || (same_x && adj_y)) && in_bounds && !wall_hit;
    end

    always_comb begin
        step_x = pos_x_q;
        step_y = pos_y_q;
        if (tgt_x_q > pos_x_q)      step_x = pos_x_q + STEP_X;
        else if (tgt_x_q < pos_x_q) step_x = pos_x_q - STEP_X;
        if (tgt_y_q > pos_y_q)      step_y = pos_y_q + STEP_Y;
        else if (tgt_y_q < pos_y_q) step_y = pos_y_q - STEP_Y;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tile_x_d    = tile_x_q;
        tile_y_d    = tile_y_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        tgt_x_d     = tgt_x_q;
        tgt_y_d     = tgt_y_q;
        moving_d    = moving_q;
        blocked_d   = 1'b0;
        ctrl_tick_d = 1'b0;
        if (enable) begin
            cnt_d = move_tick ? '0 : cnt_q + 1'b1;
            case (state_q)
                S_ALIGNED: if (move_tick) state_d = S_WAIT;
                S_WAIT:    state_d = S_CHECK;
                S_CHECK: begin
                    tgt_x_d = req_x;
                    tgt_y_d = req_y;
                    if (is_stay) begin
                        state_d = S_ALIGNED;
                    end else if (is_legal) begin
                        state_d  = S_MOVE;
                        moving_d = 1'b1;
                    end else begin
                        state_d   = S_ALIGNED;
                        blocked_d = 1'b1;
                    end
                end
                S_MOVE: begin
                    if (move_tick) begin
                        pos_x_d = step_x;
                        pos_y_d = step_y;
                        if (step_x == tgt_x_q && step_y == tgt_y_q) begin
                            tile_x_d = tgt_x_q;
                            tile_y_d = tgt_y_q;
                            moving_d = 1'b0;
                            state_d  = S_ALIGNED;
                        end
                    end
                end
                default: state_d = S_ALIGNED;
            endcase
            // Registered pulse lands on the very cycle the FSM will act on move_tick.
            ctrl_tick_d = (state_d == S_ALIGNED) && (cnt_d == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_ALIGNED;
            cnt_q       <= '0;
            tile_x_q    <= 10'(START_X);
            tile_y_q    <= 9'(START_Y);
            pos_x_q     <= 10'(START_X);
            pos_y_q     <= 9'(START_Y);
            tgt_x_q     <= 10'(START_X);
            tgt_y_q     <= 9'(START_Y);
            ctrl_tick_q <= 1'b0;
            moving_q    <= 1'b0;
            blocked_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tile_x_q    <= tile_x_d;
            tile_y_q    <= tile_y_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            tgt_x_q     <= tgt_x_d;
            tgt_y_q     <= tgt_y_d;
            ctrl_tick_q <= ctrl_tick_d;
            moving_q    <= moving_d;
            blocked_q   <= blocked_d;
        end
    end

    assign tile_x    = tile_x_q;
    assign tile_y    = tile_y_q;
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign ctrl_tick = ctrl_tick_q;
    assign moving    = moving_q;
    assign blocked   = blocked_q;
endmodule
